// File: rtl/time_date_counter.sv
// Real-time clock and calendar counter driven by a 32.768 kHz clock.
// Counts seconds through years with a month-length/leap-year aware day
// field. A set mode freezes time and lets push buttons edit one field at a
// time; an edit FSM selects the field and drives the blink/page hints.
module time_date_counter #(
    parameter int CLK_FREQ = 32768,
    parameter int YEAR_MAX = 99,
    parameter int YEAR_W   = 7
) (
    input  logic              clk_32_768K,
    input  logic              Rst_n,
    input  logic              Mode,
    input  logic              Sel_Next,
    input  logic              Inc,
    input  logic              Dec,
    input  logic              Clr,
    input  logic              Hour12,
    output logic [5:0]        Sec_Time,
    output logic [5:0]        Min_Time,
    output logic [4:0]        Hr_Time,
    output logic [4:0]        Hr_Disp,
    output logic              Pm,
    output logic [4:0]        Day_Date,
    output logic [3:0]        Mon_Date,
    output logic [YEAR_W-1:0] Year_Date,
    output logic [2:0]        Edit,
    output logic [1:0]        Blink,
    output logic              Display,
    output logic              Tick_1Hz,
    output logic              Day_Rollover
);

    localparam int                 PRESC_W    = $clog2(CLK_FREQ);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
    localparam logic [YEAR_W-1:0]  YEAR_LAST  = YEAR_W'(YEAR_MAX);
    // Common width for the shared field-adjust helper.
    localparam int                 FW         = (YEAR_W > 6) ? YEAR_W : 6;

    typedef enum logic [2:0] {
        EDIT_SEC  = 3'd0,
        EDIT_MIN  = 3'd1,
        EDIT_HR   = 3'd2,
        EDIT_DAY  = 3'd3,
        EDIT_MON  = 3'd4,
        EDIT_YEAR = 3'd5
    } edit_e;

    // Synchronizer stages for {Clr, Dec, Inc, Sel_Next, Mode}; the third
    // stage holds the previous synchronized value for edge detection.
    logic [4:0] sync1_q, sync2_q, sync3_q;
    logic       mode_s, mode_rise;
    logic       sel_e, inc_e, dec_e, clr_e;

    logic [PRESC_W-1:0] presc_q;
    logic               sec_tick;

    logic [5:0]        sec_q, sec_n;
    logic [5:0]        min_q, min_n;
    logic [4:0]        hr_q, hr_n;
    logic [4:0]        day_q, day_n;
    logic [3:0]        mon_q, mon_n;
    logic [YEAR_W-1:0] year_q, year_n;
    logic [4:0]        dim_cur, dim_new;
    logic              tick_q, roll_q;

    edit_e edit_q, edit_n;

    function automatic logic [4:0] days_in_month(input logic [3:0] mon,
                                                 input logic [1:0] year_lo);
        case (mon)
            4'd2:                    return (year_lo == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    // Clear to minimum, or step up/down with wrap inside [lo, hi].
    function automatic logic [FW-1:0] adjust(input logic [FW-1:0] v,
                                             input logic [FW-1:0] lo,
                                             input logic [FW-1:0] hi,
                                             input logic          do_clr,
                                             input logic          do_inc,
                                             input logic          do_dec);
        adjust = v;
        if (do_clr)
            adjust = lo;
        else if (do_inc && !do_dec)
            adjust = (v >= hi) ? lo : v + FW'(1);
        else if (do_dec && !do_inc)
            adjust = (v <= lo) ? hi : v - FW'(1);
    endfunction

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the value
            // its predecessor held before this edge, forming a real pipeline.
            sync1_q <= {Clr, Dec, Inc, Sel_Next, Mode};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign mode_s    = sync2_q[0];
    assign mode_rise = sync2_q[0] & ~sync3_q[0];
    assign sel_e     = sync2_q[1] & ~sync3_q[1];
    assign inc_e     = sync2_q[2] & ~sync3_q[2];
    assign dec_e     = sync2_q[3] & ~sync3_q[3];
    assign clr_e     = sync2_q[4] & ~sync3_q[4];

    // Prescaler: counts cycles within a second, parked at 0 in set mode.
    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n)
            presc_q <= '0;
        else if (mode_s || presc_q == PRESC_LAST)
            presc_q <= '0;
        else
            presc_q <= presc_q + PRESC_W'(1);
    end

    assign sec_tick = ~mode_s & (presc_q == PRESC_LAST);
    assign dim_cur  = days_in_month(mon_q, year_q[1:0]);

    // Next time/date: carry chain on a tick, single-field edits in set mode.
    always_comb begin
        // NOTE: every variable written here gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        sec_n   = sec_q;
        min_n   = min_q;
        hr_n    = hr_q;
        day_n   = day_q;
        mon_n   = mon_q;
        year_n  = year_q;
        dim_new = dim_cur;
        if (sec_tick) begin
            if (sec_q != 6'd59) begin
                sec_n = sec_q + 6'd1;
            end else begin
                sec_n = 6'd0;
                if (min_q != 6'd59) begin
                    min_n = min_q + 6'd1;
                end else begin
                    min_n = 6'd0;
                    if (hr_q != 5'd23) begin
                        hr_n = hr_q + 5'd1;
                    end else begin
                        hr_n = 5'd0;
                        if (day_q < dim_cur) begin
                            day_n = day_q + 5'd1;
                        end else begin
                            day_n = 5'd1;
                            if (mon_q != 4'd12) begin
                                mon_n = mon_q + 4'd1;
                            end else begin
                                mon_n  = 4'd1;
                                year_n = (year_q == YEAR_LAST) ? '0 : year_q + YEAR_W'(1);
                            end
                        end
                    end
                end
            end
        end else if (mode_s) begin
            case (edit_q)
                EDIT_SEC: sec_n = 6'(adjust(FW'(sec_q), FW'(0), FW'(59), clr_e, inc_e, dec_e));
                EDIT_MIN: min_n = 6'(adjust(FW'(min_q), FW'(0), FW'(59), clr_e, inc_e, dec_e));
                EDIT_HR:  hr_n  = 5'(adjust(FW'(hr_q), FW'(0), FW'(23), clr_e, inc_e, dec_e));
                EDIT_DAY: day_n = 5'(adjust(FW'(day_q), FW'(1), FW'(dim_cur), clr_e, inc_e, dec_e));
                EDIT_MON: begin
                    mon_n   = 4'(adjust(FW'(mon_q), FW'(1), FW'(12), clr_e, inc_e, dec_e));
                    dim_new = days_in_month(mon_n, year_q[1:0]);
                    if (day_q > dim_new)
                        day_n = dim_new;
                end
                EDIT_YEAR: begin
                    year_n  = YEAR_W'(adjust(FW'(year_q), FW'(0), FW'(YEAR_MAX), clr_e, inc_e, dec_e));
                    dim_new = days_in_month(mon_q, year_n[1:0]);
                    if (day_q > dim_new)
                        day_n = dim_new;
                end
                default: ;
            endcase
        end
    end

    // Time/date registers and the one-cycle status pulses.
    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            sec_q  <= 6'd0;
            min_q  <= 6'd0;
            hr_q   <= 5'd0;
            day_q  <= 5'd1;
            mon_q  <= 4'd1;
            year_q <= '0;
            tick_q <= 1'b0;
            roll_q <= 1'b0;
        end else begin
            sec_q  <= sec_n;
            min_q  <= min_n;
            hr_q   <= hr_n;
            day_q  <= day_n;
            mon_q  <= mon_n;
            year_q <= year_n;
            tick_q <= sec_tick;
            roll_q <= sec_tick && sec_q == 6'd59 && min_q == 6'd59 && hr_q == 5'd23;
        end
    end

    // Edit FSM state register.
    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n)
            edit_q <= EDIT_SEC;
        else
            edit_q <= edit_n;
    end

    // Edit FSM next state: advance on Sel_Next in set mode, SEC on entry.
    always_comb begin
        edit_n = edit_q;
        case (edit_q)
            EDIT_SEC:  if (mode_s && sel_e) edit_n = EDIT_MIN;
            EDIT_MIN:  if (mode_s && sel_e) edit_n = EDIT_HR;
            EDIT_HR:   if (mode_s && sel_e) edit_n = EDIT_DAY;
            EDIT_DAY:  if (mode_s && sel_e) edit_n = EDIT_MON;
            EDIT_MON:  if (mode_s && sel_e) edit_n = EDIT_YEAR;
            EDIT_YEAR: if (mode_s && sel_e) edit_n = EDIT_SEC;
            default:   edit_n = EDIT_SEC;
        endcase
        if (mode_rise)
            edit_n = EDIT_SEC;
    end

    // Edit FSM outputs: blink group and display page for the selected field.
    always_comb begin
        Blink   = 2'b00;
        Display = 1'b0;
        if (mode_s) begin
            case (edit_q)
                EDIT_SEC:  begin Blink = 2'b01; Display = 1'b0; end
                EDIT_MIN:  begin Blink = 2'b10; Display = 1'b0; end
                EDIT_HR:   begin Blink = 2'b11; Display = 1'b0; end
                EDIT_DAY:  begin Blink = 2'b01; Display = 1'b1; end
                EDIT_MON:  begin Blink = 2'b10; Display = 1'b1; end
                EDIT_YEAR: begin Blink = 2'b11; Display = 1'b1; end
                default:   begin Blink = 2'b00; Display = 1'b0; end
            endcase
        end
    end

    // 12/24-hour display conversion.
    always_comb begin
        Hr_Disp = hr_q;
        Pm      = 1'b0;
        if (Hour12) begin
            Pm = (hr_q >= 5'd12);
            if (hr_q == 5'd0 || hr_q == 5'd12)
                Hr_Disp = 5'd12;
            else if (hr_q > 5'd12)
                Hr_Disp = hr_q - 5'd12;
        end
    end

    assign Sec_Time     = sec_q;
    assign Min_Time     = min_q;
    assign Hr_Time      = hr_q;
    assign Day_Date     = day_q;
    assign Mon_Date     = mon_q;
    assign Year_Date    = year_q;
    assign Edit         = edit_q;
    assign Tick_1Hz     = tick_q;
    assign Day_Rollover = roll_q;

endmodule

// File: tb/tb_time_date_counter.sv
// Directed bench for time_date_counter at CLK_FREQ = 4: calendar carries,
// set-mode editing, edit FSM walk, 12-hour display and asynchronous reset.
`timescale 1ns/1ps
module tb_time_date_counter;

    localparam int CLK_FREQ = 4;
    localparam int YEAR_MAX = 99;
    localparam int YEAR_W   = 7;

    localparam logic [3:0] B_SEL = 4'b0001;
    localparam logic [3:0] B_INC = 4'b0010;
    localparam logic [3:0] B_DEC = 4'b0100;
    localparam logic [3:0] B_CLR = 4'b1000;

    logic              clk_32_768K = 1'b0;
    logic              Rst_n = 1'b0;
    logic              Mode = 1'b0;
    logic              Sel_Next = 1'b0;
    logic              Inc = 1'b0;
    logic              Dec = 1'b0;
    logic              Clr = 1'b0;
    logic              Hour12 = 1'b0;
    logic [5:0]        Sec_Time;
    logic [5:0]        Min_Time;
    logic [4:0]        Hr_Time;
    logic [4:0]        Hr_Disp;
    logic              Pm;
    logic [4:0]        Day_Date;
    logic [3:0]        Mon_Date;
    logic [YEAR_W-1:0] Year_Date;
    logic [2:0]        Edit;
    logic [1:0]        Blink;
    logic              Display;
    logic              Tick_1Hz;
    logic              Day_Rollover;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int hr;
        bit h12;
        int exp_disp;
        bit exp_pm;
    } hour_vec_t;

    typedef struct {
        int       exp_edit;
        bit [1:0] exp_blink;
        bit       exp_display;
    } edit_vec_t;

    time_date_counter #(
        .CLK_FREQ(CLK_FREQ),
        .YEAR_MAX(YEAR_MAX),
        .YEAR_W  (YEAR_W)
    ) dut (
        .clk_32_768K (clk_32_768K),
        .Rst_n       (Rst_n),
        .Mode        (Mode),
        .Sel_Next    (Sel_Next),
        .Inc         (Inc),
        .Dec         (Dec),
        .Clr         (Clr),
        .Hour12      (Hour12),
        .Sec_Time    (Sec_Time),
        .Min_Time    (Min_Time),
        .Hr_Time     (Hr_Time),
        .Hr_Disp     (Hr_Disp),
        .Pm          (Pm),
        .Day_Date    (Day_Date),
        .Mon_Date    (Mon_Date),
        .Year_Date   (Year_Date),
        .Edit        (Edit),
        .Blink       (Blink),
        .Display     (Display),
        .Tick_1Hz    (Tick_1Hz),
        .Day_Rollover(Day_Rollover)
    );

    always #5 clk_32_768K = ~clk_32_768K;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dim(input int mo, input int y);
        case (mo)
            2:             return (y % 4 == 0) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    task automatic check_time(input string name, input int s, input int m, input int h,
                              input int d, input int mo, input int y);
        check({name, "_sec"},  Sec_Time,  s);
        check({name, "_min"},  Min_Time,  m);
        check({name, "_hr"},   Hr_Time,   h);
        check({name, "_day"},  Day_Date,  d);
        check({name, "_mon"},  Mon_Date,  mo);
        check({name, "_year"}, Year_Date, y);
    endtask

    // One button press: held for three edges, then released long enough
    // for the synchronizer to clear so the next press is a fresh edge.
    task automatic press(input logic [3:0] btn);
        @(negedge clk_32_768K);
        {Clr, Dec, Inc, Sel_Next} = btn;
        repeat (3) @(negedge clk_32_768K);
        {Clr, Dec, Inc, Sel_Next} = 4'b0000;
        repeat (3) @(negedge clk_32_768K);
    endtask

    task automatic set_mode(input logic m);
        @(negedge clk_32_768K);
        Mode = m;
        repeat (3) @(negedge clk_32_768K);
    endtask

    // Clear, then reach target by the shorter direction around the range.
    task automatic set_field(input int target, input int lo, input int hi);
        int up;
        int down;
        press(B_CLR);
        up   = target - lo;
        down = hi - target + 1;
        if (up <= down)
            repeat (up) press(B_INC);
        else
            repeat (down) press(B_DEC);
    endtask

    // Starts in set mode at SEC, ends in set mode at DAY.
    task automatic preload(input int s, input int m, input int h,
                           input int d, input int mo, input int y);
        set_field(s, 0, 59);
        press(B_SEL);
        set_field(m, 0, 59);
        press(B_SEL);
        set_field(h, 0, 23);
        press(B_SEL);
        press(B_SEL);
        set_field(mo, 1, 12);
        press(B_SEL);
        set_field(y, 0, YEAR_MAX);
        repeat (4) press(B_SEL);
        set_field(d, 1, dim(mo, y));
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_32_768K);
            if (Tick_1Hz)
                seen = 1'b1;
            else
                check({name, "_no_early_roll"}, Day_Rollover, 0);
        end
        check({name, "_tick_seen"}, seen, 1);
    endtask

    initial begin
        hour_vec_t hour_tbl[8];
        edit_vec_t edit_tbl[6];
        int        k;
        bit        seen;

        hour_tbl[0] = '{0,  1'b0, 0,  1'b0};
        hour_tbl[1] = '{0,  1'b1, 12, 1'b0};
        hour_tbl[2] = '{12, 1'b1, 12, 1'b1};
        hour_tbl[3] = '{13, 1'b1, 1,  1'b1};
        hour_tbl[4] = '{11, 1'b1, 11, 1'b0};
        hour_tbl[5] = '{23, 1'b1, 11, 1'b1};
        hour_tbl[6] = '{23, 1'b0, 23, 1'b0};
        hour_tbl[7] = '{12, 1'b0, 12, 1'b0};

        edit_tbl[0] = '{1, 2'b10, 1'b0};
        edit_tbl[1] = '{2, 2'b11, 1'b0};
        edit_tbl[2] = '{3, 2'b01, 1'b1};
        edit_tbl[3] = '{4, 2'b10, 1'b1};
        edit_tbl[4] = '{5, 2'b11, 1'b1};
        edit_tbl[5] = '{0, 2'b01, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk_32_768K);
        check_time("rst", 0, 0, 0, 1, 1, 0);
        check("rst_edit", Edit, 0);
        check("rst_tick", Tick_1Hz, 0);
        check("rst_roll", Day_Rollover, 0);
        check("rst_blink", Blink, 0);
        Rst_n = 1'b1;

        // Midnight rollover into March of a non-leap year.
        set_mode(1'b1);
        check("set_edit_sec", Edit, 0);
        preload(59, 59, 23, 28, 2, 3);
        check_time("pre_a", 59, 59, 23, 28, 2, 3);
        set_mode(1'b0);
        wait_tick("roll_a");
        check_time("roll_a", 0, 0, 0, 1, 3, 3);
        check("roll_a_roll", Day_Rollover, 1);
        @(negedge clk_32_768K);
        check("roll_a_tick_1cyc", Tick_1Hz, 0);
        check("roll_a_roll_1cyc", Day_Rollover, 0);
        wait_tick("sec_b");
        check("sec_b_sec", Sec_Time, 1);
        check("sec_b_noroll", Day_Rollover, 0);

        // Leap year: Feb 28 -> Feb 29.
        set_mode(1'b1);
        preload(59, 59, 23, 28, 2, 4);
        set_mode(1'b0);
        wait_tick("roll_leap");
        check_time("roll_leap", 0, 0, 0, 29, 2, 4);

        // Year wrap at end of December of YEAR_MAX.
        set_mode(1'b1);
        preload(59, 59, 23, 31, 12, 99);
        set_mode(1'b0);
        wait_tick("roll_year");
        check_time("roll_year", 0, 0, 0, 1, 1, 0);
        check("roll_year_roll", Day_Rollover, 1);

        // Month change clamps the day; Inc+Dec together does nothing; Clr.
        set_mode(1'b1);
        preload(0, 0, 0, 31, 1, 3);
        check("clamp_pre_day", Day_Date, 31);
        press(B_SEL);
        check("clamp_edit_mon", Edit, 4);
        press(B_INC);
        check("clamp_mon", Mon_Date, 2);
        check("clamp_day", Day_Date, 28);
        press(B_INC | B_DEC);
        check("incdec_mon", Mon_Date, 2);
        check("incdec_day", Day_Date, 28);
        repeat (5) press(B_SEL);
        check("edit_day", Edit, 3);
        press(B_CLR);
        check("clr_day", Day_Date, 1);
        press(B_DEC);
        check("dec_day_wrap", Day_Date, 28);

        // Edit holds in run mode; re-entering set mode forces SEC.
        set_mode(1'b0);
        check("run_edit_hold", Edit, 3);
        check("run_blink", Blink, 0);
        check("run_display", Display, 0);
        set_mode(1'b1);
        check("enter_edit", Edit, 0);
        check("enter_blink", Blink, 2'b01);
        check("enter_display", Display, 0);
        for (int i = 0; i < 6; i++) begin
            press(B_SEL);
            check($sformatf("walk%0d_edit", i), Edit, edit_tbl[i].exp_edit);
            check($sformatf("walk%0d_blink", i), Blink, edit_tbl[i].exp_blink);
            check($sformatf("walk%0d_display", i), Display, edit_tbl[i].exp_display);
        end
        repeat (4) press(B_SEL);
        check("toggle_pre_edit", Edit, 4);
        set_mode(1'b0);
        check("toggle_run_edit", Edit, 4);
        press(B_INC);
        check("run_inc_ignored", Mon_Date, 2);
        press(B_SEL);
        check("run_sel_ignored", Edit, 4);
        set_mode(1'b1);
        check("toggle_set_edit", Edit, 0);
        check("toggle_set_blink", Blink, 2'b01);

        // Button latency: action appears only after the third edge.
        press(B_CLR);
        check("lat_clr", Sec_Time, 0);
        @(negedge clk_32_768K);
        Inc = 1'b1;
        repeat (2) @(negedge clk_32_768K);
        check("lat_edge2", Sec_Time, 0);
        @(negedge clk_32_768K);
        check("lat_edge3", Sec_Time, 1);
        Inc = 1'b0;
        repeat (3) @(negedge clk_32_768K);
        check("lat_once", Sec_Time, 1);

        // 12-hour display table.
        repeat (2) press(B_SEL);
        check("hr_edit", Edit, 2);
        for (int i = 0; i < 8; i++) begin
            set_field(hour_tbl[i].hr, 0, 23);
            Hour12 = hour_tbl[i].h12;
            #1;
            check($sformatf("h%0d_hr", i), Hr_Time, hour_tbl[i].hr);
            check($sformatf("h%0d_disp", i), Hr_Disp, hour_tbl[i].exp_disp);
            check($sformatf("h%0d_pm", i), Pm, hour_tbl[i].exp_pm);
        end

        // Asynchronous reset mid-second, then first tick timing.
        Hour12 = 1'b0;
        set_mode(1'b0);
        @(negedge clk_32_768K);
        @(posedge clk_32_768K);
        #2;
        Rst_n = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0, 1, 1, 0);
        check("async_rst_edit", Edit, 0);
        check("async_rst_tick", Tick_1Hz, 0);
        check("async_rst_roll", Day_Rollover, 0);
        check("async_rst_disp", Hr_Disp, 0);
        check("async_rst_pm", Pm, 0);
        @(negedge clk_32_768K);
        Rst_n = 1'b1;
        k = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk_32_768K);
            if (Tick_1Hz) begin
                seen = 1'b1;
                k = i;
            end
        end
        check("post_rst_tick_seen", seen, 1);
        check("post_rst_tick_cycles", k, CLK_FREQ);
        check("post_rst_sec", Sec_Time, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_date_counter.md
TIME_DATE_COUNTER -- requirements
Module: time_date_counter

Interface
REQ-001 Parameter CLK_FREQ, 32768, input clock cycles per second; legal range >= 2.
REQ-002 Parameter YEAR_MAX, 99, last year value before the year wraps to 0.
REQ-003 Parameter YEAR_W, 7, Year_Date width; YEAR_MAX < 2^YEAR_W is required.
REQ-004 Ports (name  direction  width  meaning), clock and reset first:
- clk_32_768K  in  1  sole clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Mode  in  1  0 = run, 1 = set.
- Sel_Next  in  1  advance edit field.
- Inc  in  1  increment selected field.
- Dec  in  1  decrement selected field.
- Clr  in  1  clear selected field.
- Hour12  in  1  12-hour display format select.
- Sec_Time  out  6  seconds, 0-59.
- Min_Time  out  6  minutes, 0-59.
- Hr_Time  out  5  hours, 0-23.
- Hr_Disp  out  5  display hour.
- Pm  out  1  PM flag.
- Day_Date  out  5  day of month.
- Mon_Date  out  4  month, 1-12.
- Year_Date  out  YEAR_W  year.
- Edit  out  3  selected field.
- Blink  out  2  blink group.
- Display  out  1  0 = time page, 1 = date page.
- Tick_1Hz  out  1  one-cycle pulse each second.
- Day_Rollover  out  1  one-cycle pulse at midnight carry.
REQ-005 The block SHALL have one clock, clk_32_768K, and an asynchronous active-low reset, Rst_n; no other clocks are derived or used.

Function
REQ-006 Mode, Sel_Next, Inc, Dec and Clr SHALL each pass through a 2-flop synchronizer; Sel_Next/Inc/Dec/Clr act only on a synchronized rising edge, once per press.
REQ-007 A button action SHALL be visible on outputs at the 3rd rising clk edge at which the raw input is high.
REQ-008 Prescaler width is $clog2(CLK_FREQ); in run mode it counts 0..CLK_FREQ-1; at terminal count it wraps to 0, Tick_1Hz = 1 for that cycle, and the time advances one second.
REQ-009 Carry chain:
- Sec 59 -> 0 and Min +1.
- Min 59 -> 0 and Hr +1.
- Hr 23 -> 0 and Day +1, with Day_Rollover = 1 for the same cycle as Tick_1Hz.
- Day DIM -> 1 and Mon +1.
- Mon 12 -> 1 and Year +1.
- Year YEAR_MAX -> 0.
REQ-010 DIM (days in month):
- Feb = 29 if Year_Date mod 4 == 0 (year 0 is leap), else 28.
- Apr, Jun, Sep, Nov = 30.
- All other months = 31.
REQ-011 Set mode (synchronized Mode = 1):
- Prescaler is held at 0, so time is frozen and Tick_1Hz = 0.
- On return to run mode, counting restarts, with the first tick CLK_FREQ cycles later.
REQ-012 Edit FSM states: SEC = 0, MIN = 1, HR = 2, DAY = 3, MON = 4, YEAR = 5.
- Entering set mode forces SEC.
- A Sel_Next edge advances the state; YEAR wraps to SEC.
- Edit holds in run mode.
- Encodings 6-7 are unreachable; if reached, the state returns to SEC on the next clock.
REQ-013 Inc/Dec on the selected field wrap within its range:
- SEC, MIN: 0-59.
- HR: 0-23.
- DAY: 1-DIM.
- MON: 1-12.
- YEAR: 0-YEAR_MAX.
- No carry into other fields.
REQ-014 Clr sets the selected field to its minimum (0, or 1 for DAY/MON).
- Clr has priority over Inc/Dec.
- Inc and Dec edges in the same cycle without Clr: no change.
REQ-015 After any MON or YEAR change in set mode, if Day_Date > new DIM, Day_Date SHALL clamp to DIM in the same update.
REQ-016 Inc/Dec/Clr/Sel_Next SHALL be ignored in run mode.
REQ-017 Blink and Display (combinational from Mode and Edit):
- Run mode: Blink = 00, Display = 0.
- Set mode: SEC 01/0, MIN 10/0, HR 11/0, DAY 01/1, MON 10/1, YEAR 11/1.
REQ-018 Hour display (combinational):
- Hour12 = 0: Hr_Disp = Hr_Time, Pm = 0.
- Hour12 = 1: Hr_Disp = 12 when Hr_Time is 0 or 12, else Hr_Time mod 12; Pm = (Hr_Time >= 12).

Reset
REQ-019 Rst_n low SHALL asynchronously force:
- Time 00:00:00, date Day 1, Mon 1, Year 0.
- Prescaler 0, Edit SEC, Tick_1Hz 0, Day_Rollover 0, synchronizer flops 0.
REQ-020 Reset mid-count or mid-edit SHALL discard all partial state; the first tick comes CLK_FREQ cycles after Rst_n rises with Mode low.

Verification
REQ-021 Run CLK_FREQ=4. Preload 23:59:59 28/02/03 via set mode, then run one tick -> 00:00:00 01/03/03; Day_Rollover and Tick_1Hz each pulse exactly 1 cycle.
REQ-022 Preload 23:59:59 28/02/04, one tick -> 29/02/04. Preload 23:59:59 31/12/99, one tick -> 00:00:00 01/01/00.
REQ-023 Set mode, Day 31, Mon 1, Year 3: select MON, Inc -> Mon 2, Day 28. Inc and Dec in the same cycle -> no change. Clr on DAY -> Day 1.
REQ-024 Edit walk: 6 Sel_Next edges -> Edit 1,2,3,4,5,0, with Blink/Display per REQ-017. Toggle Mode 0->1 at Edit 4 -> Edit 0.
REQ-025 Hour12=1: Hr 0 -> Disp 12, Pm 0; Hr 12 -> 12, Pm 1; Hr 13 -> 1, Pm 1. Assert Rst_n low mid-second -> all REQ-019 values immediately, without a clock.
